// File: rtl/pe_packet_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pe_packet_rx                                               |
// | Description : PE ingress receiver; loads filter weights from NoC packets |
// |               and streams buffered ifmap rows once the filter is whole.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pe_packet_rx #(
  parameter int         WIDTH      = 64,
  parameter logic [3:0] MY_ADDR    = 4'd0,
  parameter int         FILT_ROWS  = 5,
  parameter int         FILT_W     = 5,
  parameter int         WGT_BITS   = 8,
  parameter int         IFMAP_BITS = 25,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  pkt_valid,
  output logic                                  pkt_ready,
  input  logic [WIDTH-1:0]                      pkt_data,
  output logic [FILT_ROWS*FILT_W*WGT_BITS-1:0]  filter_q,
  output logic                                  filter_ready,
  output logic                                  ifm_valid,
  input  logic                                  ifm_ready,
  output logic [IFMAP_BITS-1:0]                 ifm_data,
  output logic [3:0]                            ifm_row,
  output logic [7:0]                            drop_cnt,
  output logic                                  err_pulse
);

  localparam int ROW_BITS = FILT_W * WGT_BITS;
  localparam int ENT_BITS = IFMAP_BITS + 4;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_FILT_LOAD = 1'b0,
    ST_RUN       = 1'b1
  } state_t;

  state_t                             r_state;
  logic [FILT_ROWS-1:0]               r_mask;
  logic [FILT_ROWS*ROW_BITS-1:0]      r_filter;
  logic                               r_filter_ready;
  logic [7:0]                         r_drop_cnt;
  logic                               r_err_pulse;
  logic [ENT_BITS-1:0]                r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                   r_wr_ptr;
  logic [PTR_W-1:0]                   r_rd_ptr;
  logic [CNT_W-1:0]                   r_count;

  logic [3:0]                         w_dest;
  logic [1:0]                         w_type;
  logic [3:0]                         w_row;
  logic                               w_is_filter;
  logic                               w_drop;
  logic                               w_pkt_ready;
  logic                               w_accept;
  logic                               w_filt_acc;
  logic                               w_push;
  logic                               w_pop;
  logic                               w_ifm_valid;
  logic [FILT_ROWS-1:0]               w_row_hot;
  logic [FILT_ROWS-1:0]               w_mask_next;
  logic [ENT_BITS-1:0]                w_head;
  logic                               w_unused;

  // Header fields sit at the top of the packet; src is carried but ignored.
  assign w_dest      = pkt_data[WIDTH-1  -: 4];
  assign w_type      = pkt_data[WIDTH-9  -: 2];
  assign w_row       = pkt_data[WIDTH-11 -: 4];
  assign w_is_filter = (w_type == 2'b00);
  assign w_unused    = &{1'b0, pkt_data};

  assign w_drop = (w_dest != MY_ADDR) || w_type[1] ||
                  (w_is_filter && (int'(w_row) >= FILT_ROWS));

  // A filter arriving in RUN waits until every buffered ifmap row has left,
  // so rows already queued are processed with the weights they came with.
  always_comb begin
    w_pkt_ready = 1'b0;
    if (w_drop) begin
      w_pkt_ready = 1'b1;
    end else if (w_is_filter) begin
      w_pkt_ready = (r_state == ST_FILT_LOAD) || (r_count == '0);
    end else begin
      w_pkt_ready = (r_count < c_depth);
    end
  end

  assign w_accept    = pkt_valid && w_pkt_ready;
  assign w_filt_acc  = w_accept && !w_drop && w_is_filter;
  assign w_push      = w_accept && !w_drop && !w_is_filter;
  assign w_ifm_valid = (r_state == ST_RUN) && (r_count != '0);
  assign w_pop       = w_ifm_valid && ifm_ready;

  always_comb begin
    w_row_hot = '0;
    for (int r = 0; r < FILT_ROWS; r++) begin
      w_row_hot[r] = (w_row == 4'(r));
    end
    w_mask_next = ((r_state == ST_RUN) ? '0 : r_mask) | w_row_hot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_FILT_LOAD;
      r_mask         <= '0;
      r_filter       <= '0;
      r_filter_ready <= 1'b0;
      r_drop_cnt     <= '0;
      r_err_pulse    <= 1'b0;
    end else begin
      r_err_pulse <= w_accept && w_drop;
      if (w_accept && w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_filt_acc) begin
        for (int r = 0; r < FILT_ROWS; r++) begin
          if (w_row_hot[r]) begin
            r_filter[r*ROW_BITS +: ROW_BITS] <= pkt_data[ROW_BITS-1:0];
          end
        end
        r_mask <= w_mask_next;
        if (&w_mask_next) begin
          r_state        <= ST_RUN;
          r_filter_ready <= 1'b1;
        end else begin
          r_state        <= ST_FILT_LOAD;
          r_filter_ready <= 1'b0;
        end
      end
    end
  end

  // Ifmap FIFO; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_row, pkt_data[IFMAP_BITS-1:0]};
        r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign pkt_ready    = w_pkt_ready;
  assign filter_q     = r_filter;
  assign filter_ready = r_filter_ready;
  assign ifm_valid    = w_ifm_valid;
  assign ifm_data     = w_head[IFMAP_BITS-1:0];
  assign ifm_row      = w_head[ENT_BITS-1 -: 4];
  assign drop_cnt     = r_drop_cnt;
  assign err_pulse    = r_err_pulse;

endmodule
`default_nettype wire

// File: doc/pe_packet_rx.md
Name: pe_packet_rx

Overview:
- Clocked network-interface receiver at a PE's ingress port.
- Terminates the 64-bit packets that the memory controller injects into the 4x4 torus NoC (filter rows and ifmap spike rows).
- Decodes the header, loads the filter weight register file, and buffers ifmap rows in a FIFO.
- Streams ifmap rows to the PE datapath over a valid/ready interface, only once a complete filter is resident.

Parameters:
- WIDTH, 64, packet width.
- MY_ADDR, 4'd0, router address of this PE; packets with any other destination are dropped.
- FILT_ROWS, 5, filter rows per filter.
- FILT_W, 5, weights per filter row.
- WGT_BITS, 8, bits per weight.
- IFMAP_BITS, 25, spike bits per ifmap row.
- FIFO_DEPTH, 4, ifmap row FIFO entries (power of 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pkt_valid  in  1  NoC packet valid.
- pkt_ready  out  1  receiver accepts the packet this cycle.
- pkt_data  in  WIDTH  packet.
- filter_q  out  FILT_ROWS*FILT_W*WGT_BITS  weights; row r at [r*FILT_W*WGT_BITS +: FILT_W*WGT_BITS].
- filter_ready  out  1  all filter rows loaded (state RUN).
- ifm_valid  out  1  ifmap row available to PE.
- ifm_ready  in  1  PE consumes the row.
- ifm_data  out  IFMAP_BITS  spike row.
- ifm_row  out  4  ifmap row index.
- drop_cnt  out  8  saturating count of dropped packets.
- err_pulse  out  1  one-cycle pulse per dropped packet.

Behaviour:
- Packet format:
  - [63:60] dest.
  - [59:56] src (ignored).
  - [55:54] type: 00 filter, 01 ifmap, 1x invalid.
  - [53:50] row index.
  - Filter payload [FILT_W*WGT_BITS-1:0]; weight k at [k*WGT_BITS +: WGT_BITS].
  - Ifmap payload [IFMAP_BITS-1:0].
- Handshake:
  - A transfer occurs on a rising edge with pkt_valid & pkt_ready.
  - pkt_ready is combinational from state, FIFO count and pkt_data header.
  - The sender holds pkt_data stable while valid and not ready.
  - The same rule applies to ifm_valid/ifm_ready with roles swapped.
- Drop rule (dest != MY_ADDR, type 1x, or filter with row >= FILT_ROWS):
  - pkt_ready=1; packet discarded.
  - drop_cnt +1, saturating at 255.
  - err_pulse=1 the following cycle.
  - Drop check takes priority over all other rules.
- Reset (async assert, sync-to-clk deassert not required):
  - state=FILT_LOAD, row mask=0, filter_q=0, filter_ready=0.
  - FIFO empty, ifm_valid=0, ifm_data=0, ifm_row=0.
  - drop_cnt=0, err_pulse=0.
  - Reset mid-operation discards all buffered rows and weights.
- FSM FILT_LOAD:
  - Filter packet: pkt_ready=1; writes row r of filter_q; sets mask[r]. A duplicate row overwrites.
  - Ifmap packet: pkt_ready = (count < FIFO_DEPTH); pushed into FIFO.
  - ifm_valid=0 in this state.
  - When mask becomes all-ones, state=RUN the next cycle and filter_ready=1 (registered).
- FSM RUN:
  - Ifmap packet: pkt_ready = (count < FIFO_DEPTH).
  - Filter packet: pkt_ready=0 until FIFO is empty. It is then accepted; mask cleared to only bit r; row r written; state=FILT_LOAD; filter_ready=0 the next cycle.
  - ifm_valid = FIFO non-empty.
- FIFO:
  - Entries hold {row[3:0], spikes}; ifm_data/ifm_row show the head.
  - No full pass-through: a push is refused when count==FIFO_DEPTH, even if popping the same cycle.
  - Simultaneous push and pop when not full or empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - An ifmap row accepted at edge N into an empty FIFO in RUN gives ifm_valid=1 after edge N.
  - A filter row accepted at edge N is visible on filter_q after edge N.

Test Plan:
- Reset, then 5 filter packets (dest=0, rows 0..4, weight k = 16*r+k) -> filter_ready rises one cycle after the row-4 accept; filter_q row 2 = {8'h24,8'h23,8'h22,8'h21,8'h20}.
- In FILT_LOAD, send 2 ifmap rows (row 0 = 25'h1AAAAAA, row 1 = 25'h0155555), then complete the filter -> ifm_valid stays 0 until RUN; rows then emerge in order 0, 1.
- In RUN, hold ifm_ready=0 and send 5 ifmap rows -> 4 accepted; pkt_ready=0 on the 5th. Raise ifm_ready for 1 cycle -> 5th accepted next cycle; count stays 4.
- Packets with dest=3, type=2'b11, and filter row=7 -> each accepted with pkt_ready=1; drop_cnt=3; three err_pulse pulses; filter_q unchanged.
- In RUN with 2 rows buffered and ifm_ready=0, send a filter row-0 packet -> pkt_ready=0. Drain both rows -> packet accepted; filter_ready falls; ifm_valid=0.
- Assert rst_n=0 mid-stream with 3 rows buffered -> outputs go to reset values immediately, without waiting for a clock; after release, an ifmap packet does not appear on ifm_valid.
